i2c_cmd_queue_sequencer: RTL and testbench
==========================================

Name: i2c_cmd_queue_sequencer

Overview:
- Wishbone initiator that drains the I2C command queue Tx FIFO and replays each command word as register accesses on the I2C master core.
- Counterpart of the command-queue register slave: consumes its CQ_Enable / CQ_Single_Step / Tx_FIFO_Flush controls and returns CQ_Busy.
- Sits between the Tx FIFO read port and the I2C core's 8-bit Wishbone slave port.

Parameters:
- POLL_TIMEOUT, 16'hFFFF, max read iterations of one POLL command before abort (only with macro).
- DLY_WIDTH, 14, width of DELAY count field.

Ports:
- WBs_CLK_i  in  1  fabric clock
- WBs_RST_i  in  1  synchronous active-high reset
- CQ_Enable_i  in  1  run enable
- CQ_Single_Step_i  in  1  one command per enable rising edge
- Tx_FIFO_Flush_i  in  1  abort current command, return to IDLE
- Tx_FIFO_Empty_i  in  1  FIFO empty
- Tx_FIFO_DAT_i  in  16  head-of-FIFO word (first-word-fall-through)
- Tx_FIFO_Pop_o  out  1  one-cycle pop strobe
- CQ_Busy_o  out  1  command in progress
- CQ_Timeout_o  out  1  sticky poll-timeout flag
- WBm_ADR_o  out  3  I2C core register address
- WBm_CYC_o, WBm_STB_o, WBm_WE_o  out  1 each  Wishbone master strobes
- WBm_DAT_o  out  8  write data
- WBm_DAT_i  in  8  read data
- WBm_ACK_i  in  1  slave acknowledge

Behaviour:
- Reset (sync, WBs_RST_i=1 at clock edge): all outputs 0; state IDLE; step latch cleared; enable-edge register 0.
- Command word: [15:14] op.
  - 00 WRITE: [10:8] addr, [7:0] data.
  - 01 POLL: [13] pol, [10:8] addr, [7:0] mask.
  - 10 DELAY: [13:0] cycles.
  - 11 NOP.
- FSM states: IDLE, FETCH, WR, RD, CHK, DELAY, HOLD.
- IDLE -> FETCH when CQ_Enable_i=1, FIFO not empty, and step permitted.
  - Step permitted: always when single-step=0; otherwise only after a 0->1 edge of CQ_Enable_i since the last command.
- FETCH (1 cycle):
  - Latch word; assert Tx_FIFO_Pop_o for exactly this cycle.
  - Branch on op: WR, RD, DELAY; NOP goes to HOLD.
- WR: CYC=STB=WE=1, ADR/DAT from word; hold until WBm_ACK_i; then drop CYC/STB the next cycle; -> HOLD.
- RD: CYC=STB=1, WE=0; on ACK capture WBm_DAT_i -> CHK.
- CHK:
  - Done when (rd & mask)!=0 for pol=1, or ==0 for pol=0 -> HOLD.
  - Otherwise re-issue RD.
  - Mask 0 with pol=0 completes after one read.
- DELAY: load counter with field; decrement each cycle; -> HOLD when 0. Count 0 takes 1 cycle.
- HOLD (1 cycle): -> IDLE.
- Latency: WRITE with 0-wait ACK = FETCH + 2 + HOLD = 4 cycles.
- CQ_Busy_o = 1 in every state except IDLE.
- CQ_Enable_i deasserting mid-command does not abort it; the command completes, then the FSM stays in IDLE.
- Tx_FIFO_Flush_i=1: next edge forces IDLE, drops CYC/STB, no pop; it overrides everything except reset.
  - A flush during an outstanding Wishbone cycle abandons the cycle; a late ACK is ignored.
- FIFO empty in IDLE: remain IDLE, Busy=0; no pop is ever issued while empty.
- CYC and STB always assert and deassert together; no back-to-back cycles without one idle cycle.

Optional Feature:
- Macro I2C_CMD_QUEUE_POLL_TIMEOUT_EN.
- Defined:
  - Counter counts RD iterations of a POLL.
  - Reaching POLL_TIMEOUT without a match sets CQ_Timeout_o and goes to HOLD.
  - CQ_Timeout_o clears only on reset or Tx_FIFO_Flush_i.
- Undefined: POLL waits indefinitely; CQ_Timeout_o tied 0; no counter logic.

Test Plan:
- Reset then FIFO word 16'h0325, enable=1, ACK 0-wait -> one WB write ADR=3 DAT=8'h25 WE=1, single Pop, Busy high 4 cycles, then 0.
- POLL 16'h6280 (pol=1, addr 2, mask 80): slave returns 00, 00, 80 -> three reads, Busy drops two cycles after third ACK.
- DELAY 16'h800A -> Busy high for FETCH+10+HOLD = 12 cycles, no WB activity.
- Single-step=1, three NOPs queued, enable held 1 -> exactly one Pop; toggling enable 0->1 twice -> remaining two Pops, one per toggle.
- Flush asserted while STB=1 awaiting ACK -> next cycle CYC=STB=0, IDLE, Busy=0; late ACK causes no state change.
- With I2C_CMD_QUEUE_POLL_TIMEOUT_EN and POLL_TIMEOUT=4, POLL never matches -> exactly 4 reads, CQ_Timeout_o=1 sticky, next command executes; flush clears the flag.

Source files
------------

// File: rtl/i2c_cmd_queue_sequencer.sv
// i2c_cmd_queue_sequencer: drains command FIFO words into I2C core Wishbone register accesses
module i2c_cmd_queue_sequencer #(
  parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF,
  parameter int DLY_WIDTH = 14
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        CQ_Enable_i,
  input  logic        CQ_Single_Step_i,
  input  logic        Tx_FIFO_Flush_i,
  input  logic        Tx_FIFO_Empty_i,
  input  logic [15:0] Tx_FIFO_DAT_i,
  output logic        Tx_FIFO_Pop_o,
  output logic        CQ_Busy_o,
  output logic        CQ_Timeout_o,
  output logic [2:0]  WBm_ADR_o,
  output logic        WBm_CYC_o,
  output logic        WBm_STB_o,
  output logic        WBm_WE_o,
  output logic [7:0]  WBm_DAT_o,
  input  logic [7:0]  WBm_DAT_i,
  input  logic        WBm_ACK_i
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, WR = 3'd2, RD = 3'd3,
                         CHK = 3'd4, DELAY = 3'd5, HOLD = 3'd6;
  logic [2:0] state, adr;
  logic [7:0] dat, mask, rdat;
  logic [DLY_WIDTH-1:0] cnt;
  logic cyc, we, pol, en_q, step_ok, go, hit;
  assign go = state == IDLE && CQ_Enable_i && !Tx_FIFO_Empty_i && (!CQ_Single_Step_i || step_ok);
  assign hit = pol ? |(rdat & mask) : ~|(rdat & mask);
  assign Tx_FIFO_Pop_o = state == FETCH && !Tx_FIFO_Flush_i && !Tx_FIFO_Empty_i;
  assign CQ_Busy_o = state != IDLE;
  assign WBm_CYC_o = cyc;
  assign WBm_STB_o = cyc;
  assign WBm_WE_o = we;
  assign WBm_ADR_o = adr;
  assign WBm_DAT_o = dat;
`ifdef I2C_CMD_QUEUE_POLL_TIMEOUT_EN
  logic [15:0] iter;
  logic timeout;
  assign CQ_Timeout_o = timeout;
  always_ff @(posedge WBs_CLK_i)
    if (WBs_RST_i) begin
      iter <= '0;
      timeout <= 1'b0;
    end else if (Tx_FIFO_Flush_i)
      timeout <= 1'b0;
    else if (state == FETCH)
      iter <= 16'd1;
    else if (state == CHK && !hit) begin
      if (iter == POLL_TIMEOUT) timeout <= 1'b1;
      else iter <= iter + 16'd1;
    end
`else
  assign CQ_Timeout_o = 1'b0;
`endif
  always_ff @(posedge WBs_CLK_i)
    if (WBs_RST_i) begin
      state <= IDLE;
      cyc <= 1'b0;
      we <= 1'b0;
      adr <= '0;
      dat <= '0;
      mask <= '0;
      rdat <= '0;
      pol <= 1'b0;
      cnt <= '0;
      en_q <= 1'b0;
      step_ok <= 1'b0;
    end else begin
      en_q <= CQ_Enable_i;
      if (go) step_ok <= 1'b0;
      else if (CQ_Enable_i && !en_q) step_ok <= 1'b1;
      if (Tx_FIFO_Flush_i) begin
        state <= IDLE;
        cyc <= 1'b0;
        we <= 1'b0;
      end else
        case (state)
          IDLE: if (go) state <= FETCH;
          FETCH: begin
            adr <= Tx_FIFO_DAT_i[10:8];
            dat <= Tx_FIFO_DAT_i[7:0];
            mask <= Tx_FIFO_DAT_i[7:0];
            pol <= Tx_FIFO_DAT_i[13];
            cnt <= Tx_FIFO_DAT_i[DLY_WIDTH-1:0];
            cyc <= ~Tx_FIFO_DAT_i[15];
            we <= Tx_FIFO_DAT_i[15:14] == 2'b00;
            state <= Tx_FIFO_DAT_i[15:14] == 2'b00 ? WR :
                     Tx_FIFO_DAT_i[15:14] == 2'b01 ? RD :
                     Tx_FIFO_DAT_i[15:14] == 2'b10 ? DELAY : HOLD;
          end
          WR: if (cyc && WBm_ACK_i) begin
            cyc <= 1'b0;
            we <= 1'b0;
          end else if (!cyc) state <= HOLD;
          RD: if (WBm_ACK_i) begin
            cyc <= 1'b0;
            rdat <= WBm_DAT_i;
            state <= CHK;
          end
          CHK: begin
`ifdef I2C_CMD_QUEUE_POLL_TIMEOUT_EN
            if (hit || iter == POLL_TIMEOUT) state <= HOLD;
`else
            if (hit) state <= HOLD;
`endif
            else begin
              cyc <= 1'b1;
              state <= RD;
            end
          end
          DELAY: if (cnt <= DLY_WIDTH'(1)) state <= HOLD;
          else cnt <= cnt - DLY_WIDTH'(1);
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_cmd_queue_sequencer.sv
// tb_i2c_cmd_queue_sequencer: scoreboard bench with FIFO and Wishbone slave models
module tb_i2c_cmd_queue_sequencer;
  logic clk = 0, rst = 1, en = 0, ss = 0, flush = 0, empty = 1, ack_en = 1, ack_force = 0;
  logic pop, busy, tmo, cyc, stb, we, ack;
  logic [15:0] fdat = 0;
  logic [2:0] adr;
  logic [7:0] dato, rd_data = 0;
  logic [11:0] exp_q[$];
  logic [15:0] fifo_q[$];
  logic [7:0] rd_q[$];
  int compared = 0, mismatched = 0, pops = 0, beats = 0, busy_cyc = 0;
  logic fpend = 0, rpend = 0;
  always #5 clk = ~clk;
  assign ack = (cyc && stb && ack_en) || ack_force;

  i2c_cmd_queue_sequencer #(.POLL_TIMEOUT(16'd4)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .CQ_Enable_i(en), .CQ_Single_Step_i(ss),
    .Tx_FIFO_Flush_i(flush), .Tx_FIFO_Empty_i(empty), .Tx_FIFO_DAT_i(fdat),
    .Tx_FIFO_Pop_o(pop), .CQ_Busy_o(busy), .CQ_Timeout_o(tmo), .WBm_ADR_o(adr),
    .WBm_CYC_o(cyc), .WBm_STB_o(stb), .WBm_WE_o(we), .WBm_DAT_o(dato),
    .WBm_DAT_i(rd_data), .WBm_ACK_i(ack));

  always @(negedge clk) begin
    logic [11:0] e;
    logic [15:0] t16;
    logic [7:0] t8;
    if (fpend && fifo_q.size() > 0) t16 = fifo_q.pop_front();
    if (rpend && rd_q.size() > 0) t8 = rd_q.pop_front();
    rpend = 0;
    if (pop === 1'b1 && empty) begin
      compared++; mismatched++;
      $display("FAIL pop_while_empty: pop=%b empty=%b", pop, empty);
    end
    fpend = pop === 1'b1;
    if (fpend) pops++;
    if (busy === 1'b1) busy_cyc++;
    if (cyc !== stb) begin
      compared++; mismatched++;
      $display("FAIL cyc_stb_pair: cyc=%b stb=%b", cyc, stb);
    end
    if (cyc === 1'b1 && stb === 1'b1 && ack) begin
      beats++;
      rpend = !we;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL wb_unexpected: got we=%b adr=%0d dat=%h, wanted no access", we, adr, dato);
      end else begin
        e = exp_q.pop_front();
        if ({we, adr} !== e[11:8] || (we && dato !== e[7:0])) begin
          mismatched++;
          $display("FAIL wb_access: got we=%b adr=%0d dat=%h want we=%b adr=%0d dat=%h",
                   we, adr, dato, e[11], e[10:8], e[7:0]);
        end
      end
    end
    empty = fifo_q.size() == 0;
    fdat = empty ? 16'h0 : fifo_q[0];
    rd_data = rd_q.size() > 0 ? rd_q[0] : 8'h00;
  end

  task automatic clr();
    pops = 0; beats = 0; busy_cyc = 0;
  endtask

  task automatic run(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fifo_q.size() == 0 && busy === 1'b0) && n < budget);
    compared++;
    if (n >= budget) begin
      mismatched++;
      $display("FAIL run_timeout: got %0d cycles, want below %0d", n, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input string name, input int p, input int b, input int bc);
    compared++;
    if (pops !== p || beats !== b || busy_cyc !== bc || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: got pops=%0d beats=%0d busy=%0d left=%0d want pops=%0d beats=%0d busy=%0d left=0",
               name, pops, beats, busy_cyc, exp_q.size(), p, b, bc);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    compared++;
    if ({pop, busy, tmo, cyc, stb, we, adr, dato} !== 17'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {pop, busy, tmo, cyc, stb, we, adr, dato});
    end
    rst = 0;
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_empty_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_write();
    clr();
    fifo_q.push_back(16'h0325); exp_q.push_back({1'b1, 3'd3, 8'h25});
    en = 1;
    run(50);
    check_run("write", 1, 1, 4);
  endtask

  task automatic test_poll();
    clr();
    rd_q = '{8'h00, 8'h00, 8'h80};
    fifo_q.push_back(16'h6280);
    repeat (3) exp_q.push_back({1'b0, 3'd2, 8'h00});
    run(100);
    check_run("poll_pol1", 1, 3, 8);
    clr();
    rd_q = '{8'hFF};
    fifo_q.push_back(16'h4100); exp_q.push_back({1'b0, 3'd1, 8'h00});
    run(100);
    check_run("poll_mask0", 1, 1, 4);
    clr();
    rd_q = '{8'h01, 8'h00};
    fifo_q.push_back(16'h4101);
    repeat (2) exp_q.push_back({1'b0, 3'd1, 8'h00});
    run(100);
    check_run("poll_pol0", 1, 2, 6);
  endtask

  task automatic test_delay();
    clr();
    fifo_q.push_back(16'h800A);
    run(100);
    check_run("delay10", 1, 0, 12);
    clr();
    fifo_q.push_back(16'h8000);
    run(100);
    check_run("delay0", 1, 0, 3);
  endtask

  task automatic test_back_to_back();
    clr();
    fifo_q.push_back(16'h0111); exp_q.push_back({1'b1, 3'd1, 8'h11});
    fifo_q.push_back(16'h0722); exp_q.push_back({1'b1, 3'd7, 8'h22});
    fifo_q.push_back(16'hC000);
    run(100);
    check_run("back_to_back", 3, 2, 10);
  endtask

  task automatic test_single_step();
    en = 0;
    repeat (3) @(negedge clk);
    clr();
    ss = 1;
    repeat (3) fifo_q.push_back(16'hC000);
    en = 1;
    repeat (20) @(negedge clk);
    compared++;
    if (pops !== 1) begin
      mismatched++;
      $display("FAIL step_first: got %0d pops want 1", pops);
    end
    for (int i = 2; i <= 3; i++) begin
      en = 0;
      repeat (2) @(negedge clk);
      en = 1;
      repeat (15) @(negedge clk);
      compared++;
      if (pops !== i) begin
        mismatched++;
        $display("FAIL step_toggle: got %0d pops want %0d", pops, i);
      end
    end
    ss = 0;
  endtask

  task automatic test_flush();
    int n = 0;
    clr();
    ack_en = 0;
    fifo_q.push_back(16'h0555);
    while (cyc !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (stb !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_setup_stb: got %b want 1", stb);
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    compared++;
    if ({cyc, stb, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL flush_abort: got cyc/stb/busy=%b want 000", {cyc, stb, busy});
    end
    ack_force = 1;
    @(negedge clk);
    ack_force = 0;
    repeat (3) @(negedge clk);
    compared++;
    if ({cyc, busy} !== 2'b00 || beats !== 0 || pops !== 1) begin
      mismatched++;
      $display("FAIL flush_late_ack: got cyc/busy=%b beats=%0d pops=%0d want 00 0 1", {cyc, busy}, beats, pops);
    end
    ack_en = 1;
    clr();
    fifo_q.push_back(16'h0499); exp_q.push_back({1'b1, 3'd4, 8'h99});
    run(50);
    check_run("after_flush", 1, 1, 4);
  endtask

`ifdef I2C_CMD_QUEUE_POLL_TIMEOUT_EN
  task automatic test_timeout();
    clr();
    rd_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fifo_q.push_back(16'h6201);
    repeat (4) exp_q.push_back({1'b0, 3'd2, 8'h00});
    run(100);
    check_run("timeout_poll", 1, 4, 10);
    compared++;
    if (tmo !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_set: got %b want 1", tmo);
    end
    clr();
    rd_q.delete();
    fifo_q.push_back(16'h0611); exp_q.push_back({1'b1, 3'd6, 8'h11});
    run(50);
    check_run("timeout_next", 1, 1, 4);
    compared++;
    if (tmo !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_sticky: got %b want 1", tmo);
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    compared++;
    if (tmo !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_clear: got %b want 0", tmo);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_poll();
    test_delay();
    test_back_to_back();
    test_single_step();
    test_flush();
`ifdef I2C_CMD_QUEUE_POLL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
